tactile_readout: RTL and testbench
==================================

# tactile_readout

Double-buffered frame collector and readout scheduler for the tactile correlator result stream. It captures every `out_*` result word of one full sweep (ADC_CHANNELS × DAC_CHANNELS × 2 phases) into a write bank. On frame completion it swaps banks and streams the frame to the host link over a valid/ready interface, with a header word in front. The correlator has no backpressure, so the scheduler itself decides between accepting and dropping frames, and it never stalls the datapath.

## Interface
- `ADC_CHANNELS`, 16, ADC channels of the correlator
- `DAC_CHANNELS`, 16, DAC channels of the correlator
- `OUT_BITS`, 32, result/word width; must be 32
- `FRAME_WORDS`, derived = ADC_CHANNELS*DAC_CHANNELS*2, data words per frame
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  result word strobe from correlator
- `in_dac`  in  $clog2(DAC_CHANNELS)  DAC index of result
- `in_adc`  in  $clog2(ADC_CHANNELS)  ADC index of result
- `in_phase`  in  1  0 = in-phase, 1 = quadrature
- `in_data`  in  OUT_BITS  signed correlation sum
- `m_valid`  out  1  output word valid
- `m_ready`  in  1  sink accepts word
- `m_data`  out  OUT_BITS  header or data word
- `m_last`  out  1  final data word of frame
- `frames_sent`  out  16  frames fully streamed (wraps)
- `frames_dropped`  out  16  complete frames discarded because readout was busy (saturates at 0xFFFF)
- `frames_broken`  out  16  partial/out-of-order frames discarded (saturates)

## Operation
- Word address: `addr = {in_adc, in_dac, in_phase}`, which gives the order adc (outer), dac, phase (inner). Memory holds 2 banks × FRAME_WORDS × OUT_BITS. Reads are registered with 1-cycle latency.
- Write side, in_valid only:
  - `addr == 0`: the word is written to the write bank, `expect <= 1`, `frame_ok <= 1`. If the fill was in progress (`expect != 0`), `frames_broken` increments.
  - `addr == expect` with `frame_ok`: the word is written and `expect` increments.
  - Any other address: `frame_ok <= 0`, `expect <= 0`, `frames_broken` increments (at most once per fill), and the word is ignored.
  - Completion: the word at `addr == FRAME_WORDS-1` is written with `frame_ok == 1`.
    - If the read side is free, banks swap and the read FSM starts.
    - If the read side is busy, `frames_dropped` increments and the write bank is reused for the next frame.
    - In both cases `expect <= 0`, `frame_ok <= 0`.
- Read FSM: IDLE → HEADER → DATA → IDLE.
  - HEADER: `m_data = {16'hCAFE, seq[15:0]}`. `seq` is the frame sequence number; it increments at every completed frame, including dropped ones, so the host can detect gaps.
  - DATA: read-bank words 0..FRAME_WORDS-1 in address order. `m_last` is asserted only on word FRAME_WORDS-1.
  - At the last handshake, `frames_sent` increments and the FSM returns to IDLE.
- The read side counts as free in IDLE, and also in the cycle the last word is accepted (`m_valid & m_ready & m_last`). A completion in that same cycle is accepted rather than dropped.
- Input writes always target the write bank. The read bank is never modified while streaming.

## Timing
- Reset values: `m_valid=0`, `m_last=0`, `m_data=0`, all counters 0, `seq=0`, write bank = 0, `expect=0`, `frame_ok=0`, FSM = IDLE.
- A reset in mid-frame or mid-stream aborts both sides immediately. No word handshakes in the reset cycle.
- in_valid may arrive every cycle. The input has no stall path.
- Completion word at cycle N: banks swap at N+1, and the header is presented with `m_valid=1` from N+2.
- Handshake rules:
  - A word transfers when `m_valid & m_ready`.
  - While `m_valid=1 & m_ready=0`, `m_data` and `m_last` hold stable.
  - `m_valid` never drops without a handshake.
- Throughput: one word per cycle while `m_ready=1`. This needs a one-word prefetch register or skid buffer covering the 1-cycle RAM latency. Header to last word with `m_ready` held high takes FRAME_WORDS+1 consecutive cycles.
- Counters update on the cycle after the event. `frames_sent` wraps at 16 bits; `frames_dropped` and `frames_broken` saturate.

## Test plan
- ADC=DAC=2 (FRAME_WORDS=8), one ordered frame with `in_data = addr*3`, `m_ready=1` → header `0xCAFE0000` at completion+2, then data 0,3,…,21 on consecutive cycles, `m_last` on 21, `frames_sent=1`.
- Same frame, `m_ready` toggling 1/0 randomly → identical word sequence, data stable across stalls, no duplicates.
- Second complete frame arrives while the first is still streaming (`m_ready=0`) → `frames_dropped=1`. The first frame is streamed intact. The next frame header carries `seq=2`.
- Frame with addr 5 skipped, then a fresh ordered frame → `frames_broken=1`, only the fresh frame is streamed, header `seq=0`.
- Completion coincides with the last-word handshake of the previous frame → no drop, and the new header follows 2 cycles later.
- `rst` pulse at mid-stream, after 4 data words → `m_valid=0` next cycle, counters 0, the next ordered frame streams with `seq=0`.

Source files
------------

// File: rtl/tactile_readout_if.sv
// Correlator result stream (in_*) and host readout stream (m_*) for tactile_readout.
// The master drives results and m_ready; the slave is the frame collector.
interface tactile_readout_if #(
  parameter int ADC_CHANNELS = 16,
  parameter int DAC_CHANNELS = 16,
  parameter int OUT_BITS     = 32
);
  logic                            in_valid;
  logic [$clog2(DAC_CHANNELS)-1:0] in_dac;
  logic [$clog2(ADC_CHANNELS)-1:0] in_adc;
  logic                            in_phase;
  logic [OUT_BITS-1:0]             in_data;
  logic                            m_valid;
  logic                            m_ready;
  logic [OUT_BITS-1:0]             m_data;
  logic                            m_last;

  modport master (output in_valid, in_dac, in_adc, in_phase, in_data, m_ready,
                  input  m_valid, m_data, m_last);
  modport slave  (input  in_valid, in_dac, in_adc, in_phase, in_data, m_ready,
                  output m_valid, m_data, m_last);
endinterface

// File: rtl/tactile_readout.sv
// Double-buffered frame collector: fills one bank from the correlator sweep and
// streams the other bank (header + FRAME_WORDS words) to the host.
module tactile_readout #(
  parameter int ADC_CHANNELS = 16,
  parameter int DAC_CHANNELS = 16,
  parameter int OUT_BITS     = 32
) (
  input  logic               clk,
  input  logic               rst,
  tactile_readout_if.slave   bus,
  output logic [15:0]        frames_sent,
  output logic [15:0]        frames_dropped,
  output logic [15:0]        frames_broken
);
  localparam int FRAME_WORDS = ADC_CHANNELS * DAC_CHANNELS * 2;
  localparam int AW = $clog2(FRAME_WORDS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_WORDS - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
  state_t state, state_d;

  logic [OUT_BITS-1:0] mem [2*FRAME_WORDS];
  logic [OUT_BITS-1:0] rdata;
  logic [AW-1:0]       wr_addr, exp_addr, rd_addr, rd_addr_eff;
  logic                wr_bank, frame_ok, start, rd_more, rdata_vld, rdata_last;
  logic [15:0]         seq, hdr_seq;
  logic                restart, in_order, wr_en, complete, accept;
  logic                pop, rd_free, load, rd_en;

  assign wr_addr = {bus.in_adc, bus.in_dac, bus.in_phase};

  // Write-side decode: addr 0 always (re)starts a fill; otherwise only the expected word is taken.
  always_comb begin
    restart  = bus.in_valid && (wr_addr == '0);
    in_order = bus.in_valid && frame_ok && (wr_addr == exp_addr) && !restart;
    wr_en    = restart || in_order;
    complete = in_order && (wr_addr == LAST_ADDR);
    accept   = complete && rd_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_addr       <= '0;
      frame_ok       <= 1'b0;
      wr_bank        <= 1'b0;
      seq            <= '0;
      hdr_seq        <= '0;
      start          <= 1'b0;
      frames_dropped <= '0;
      frames_broken  <= '0;
    end else begin
      start <= accept;
      if (restart) begin
        exp_addr <= ADDR_ONE;
        frame_ok <= 1'b1;
        if (exp_addr != '0 && frames_broken != 16'hFFFF) frames_broken <= frames_broken + 16'd1;
      end else if (in_order) begin
        if (complete) begin
          exp_addr <= '0;
          frame_ok <= 1'b0;
          seq      <= seq + 16'd1;
          if (accept) begin
            wr_bank <= ~wr_bank;
            hdr_seq <= seq;
          end else if (frames_dropped != 16'hFFFF) begin
            frames_dropped <= frames_dropped + 16'd1;
          end
        end else begin
          exp_addr <= exp_addr + ADDR_ONE;
        end
      end else if (bus.in_valid) begin
        exp_addr <= '0;
        frame_ok <= 1'b0;
        if (frame_ok && frames_broken != 16'hFFFF) frames_broken <= frames_broken + 16'd1;
      end
    end
  end

  // Banks are disjoint: writes go to wr_bank, reads to ~wr_bank.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= bus.in_data;
    if (rd_en) rdata <= mem[{~wr_bank, rd_addr_eff}];
  end

  // rdata acts as the prefetch slot: it is refilled only when empty or moving to the output.
  always_comb begin
    pop         = bus.m_valid && bus.m_ready;
    rd_free     = (state == IDLE && !start) || (pop && bus.m_last);
    load        = (state != IDLE) && rdata_vld && (!bus.m_valid || pop);
    rd_addr_eff = (state == IDLE) ? '0 : rd_addr;
    rd_en       = (state == IDLE) ? start : (rd_more && (!rdata_vld || load));
    state_d     = state;
    case (state)
      IDLE:    if (start) state_d = HEADER;
      HEADER:  if (pop) state_d = DATA;
      DATA:    if (pop && bus.m_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_last  <= 1'b0;
      rd_addr     <= '0;
      rd_more     <= 1'b0;
      rdata_vld   <= 1'b0;
      rdata_last  <= 1'b0;
      frames_sent <= '0;
    end else begin
      if (state == IDLE && start) begin
        bus.m_valid <= 1'b1;
        bus.m_data  <= {16'hCAFE, hdr_seq};
        bus.m_last  <= 1'b0;
      end else if (load) begin
        bus.m_valid <= 1'b1;
        bus.m_data  <= rdata;
        bus.m_last  <= rdata_last;
      end else if (pop) begin
        bus.m_valid <= 1'b0;
        bus.m_last  <= 1'b0;
      end
      rdata_vld <= rd_en || (rdata_vld && !load);
      if (rd_en) begin
        rdata_last <= (rd_addr_eff == LAST_ADDR);
        rd_addr    <= rd_addr_eff + ADDR_ONE;
        rd_more    <= (rd_addr_eff != LAST_ADDR);
      end
      if (pop && bus.m_last) frames_sent <= frames_sent + 16'd1;
    end
  end
endmodule

// File: tb/tb_tactile_readout.sv
// Directed bench for tactile_readout with a 2x2 sweep (8 data words per frame).
module tb_tactile_readout;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] frames_sent, frames_dropped, frames_broken;
  int passed = 0;
  int total  = 0;
  int fails  = 0;

  tactile_readout_if #(.ADC_CHANNELS(2), .DAC_CHANNELS(2), .OUT_BITS(32)) bus ();

  tactile_readout #(.ADC_CHANNELS(2), .DAC_CHANNELS(2), .OUT_BITS(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .frames_sent    (frames_sent),
    .frames_dropped (frames_dropped),
    .frames_broken  (frames_broken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic put(input int a, input logic [31:0] d);
    logic [2:0] av;
    av = 3'(a);
    bus.in_valid = 1'b1;
    bus.in_adc   = av[2];
    bus.in_dac   = av[1];
    bus.in_phase = av[0];
    bus.in_data  = d;
    @(negedge clk);
  endtask

  // Returns at the negedge right after the completion edge (one cycle before the header).
  task automatic send_frame(input int mult, input int base, input int skip);
    for (int i = 0; i < 8; i++)
      if (i != skip) put(i, 32'(i * mult + base));
    bus.in_valid = 1'b0;
  endtask

  // Called at the negedge where the header is visible, with m_ready already high.
  task automatic stream_check(input string tag, input logic [31:0] hdr, input int mult, input int base);
    chk({tag, "_hdr_valid"}, 32'(bus.m_valid), 32'd1);
    chk({tag, "_hdr"}, bus.m_data, hdr);
    chk({tag, "_hdr_last"}, 32'(bus.m_last), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk({tag, "_valid"}, 32'(bus.m_valid), 32'd1);
      chk({tag, "_data"}, bus.m_data, 32'(i * mult + base));
      chk({tag, "_last"}, 32'(bus.m_last), 32'(i == 7));
    end
    @(negedge clk);
    chk({tag, "_idle"}, 32'(bus.m_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] pat;
    logic [31:0] exp_w;
    int k;
    bit started;
    bus.in_valid = 1'b0; bus.in_adc = '0; bus.in_dac = '0; bus.in_phase = 1'b0;
    bus.in_data  = '0;   bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_last", 32'(bus.m_last), 32'd0);
    chk("rst_data", bus.m_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sent", 32'(frames_sent), 32'd0);
    chk("rst_dropped", 32'(frames_dropped), 32'd0);
    chk("rst_broken", 32'(frames_broken), 32'd0);

    // ordered frame, m_ready high: header at completion+2, data 0..21 back to back
    bus.m_ready = 1'b1;
    send_frame(3, 0, -1);
    chk("f1_no_early_hdr", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    stream_check("f1", 32'hCAFE0000, 3, 0);
    chk("f1_sent", 32'(frames_sent), 32'd1);

    // same frame with m_ready toggling: data must hold while stalled, no duplicates
    bus.m_ready = 1'b0;
    send_frame(3, 0, -1);
    pat = 32'b0110_1001_1100_1011_0101_0011_1010_0110;
    k = 0;
    started = 1'b0;
    for (int c = 0; c < 80 && k < 9; c++) begin
      bus.m_ready = pat[c % 32];
      if (bus.m_valid) started = 1'b1;
      if (started) begin
        exp_w = (k == 0) ? 32'hCAFE0001 : 32'((k - 1) * 3);
        chk("stall_valid", 32'(bus.m_valid), 32'd1);
        chk("stall_data", bus.m_data, exp_w);
        chk("stall_last", 32'(bus.m_last), 32'(k == 8));
        if (bus.m_ready) k++;
      end
      @(negedge clk);
    end
    bus.m_ready = 1'b0;
    chk("stall_words", 32'(k), 32'd9);
    chk("stall_idle", 32'(bus.m_valid), 32'd0);
    chk("stall_sent", 32'(frames_sent), 32'd2);

    // frame A held by m_ready=0, frame B completes while busy and is dropped
    send_frame(1, 32'h100, -1);
    send_frame(1, 32'h200, -1);
    chk("drop_count", 32'(frames_dropped), 32'd1);
    bus.m_ready = 1'b1;
    stream_check("drop_a", 32'hCAFE0002, 1, 32'h100);
    chk("drop_sent", 32'(frames_sent), 32'd3);
    send_frame(1, 32'h400, -1);
    @(negedge clk);
    stream_check("drop_c", 32'hCAFE0004, 1, 32'h400);

    // frame with addr 5 missing is discarded, then a fresh frame streams
    send_frame(5, 0, 5);
    repeat (3) @(negedge clk);
    chk("broken_no_stream", 32'(bus.m_valid), 32'd0);
    chk("broken_count", 32'(frames_broken), 32'd1);
    send_frame(7, 0, -1);
    chk("broken_count_fresh", 32'(frames_broken), 32'd1);
    @(negedge clk);
    stream_check("fresh", 32'hCAFE0005, 7, 0);

    // completion of E lands on the last-word handshake of D: accepted, not dropped
    bus.m_ready = 1'b0;
    send_frame(2, 0, -1);
    @(negedge clk);
    bus.m_ready = 1'b1;
    chk("coin_d_hdr", bus.m_data, 32'hCAFE0006);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("coin_d_data", bus.m_data, 32'(i * 2));
      chk("coin_d_last", 32'(bus.m_last), 32'(i == 7));
      put(i, 32'(i + 32'h300));
    end
    bus.in_valid = 1'b0;
    chk("coin_gap", 32'(bus.m_valid), 32'd0);
    chk("coin_dropped", 32'(frames_dropped), 32'd1);
    chk("coin_sent", 32'(frames_sent), 32'd6);
    @(negedge clk);
    stream_check("coin_e", 32'hCAFE0007, 1, 32'h300);

    // reset after 4 data words of frame F
    send_frame(4, 0, -1);
    @(negedge clk);
    chk("rst_f_hdr", bus.m_data, 32'hCAFE0008);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_f_data", bus.m_data, 32'(i * 4));
    end
    @(negedge clk);
    rst = 1'b1;
    bus.m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 32'(bus.m_valid), 32'd0);
    chk("midrst_sent", 32'(frames_sent), 32'd0);
    chk("midrst_dropped", 32'(frames_dropped), 32'd0);
    chk("midrst_broken", 32'(frames_broken), 32'd0);
    bus.m_ready = 1'b1;
    send_frame(6, 0, -1);
    @(negedge clk);
    stream_check("post_rst", 32'hCAFE0000, 6, 0);
    chk("post_rst_sent", 32'(frames_sent), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
